// File: rtl/vga_timing_if.sv
// vga_timing_if: raster coordinates, blanking and sync outputs of vga_timing_gen; frame_count exists only with VGA_FRAME_CNT_EN.
interface vga_timing_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count;
  modport master (output DrawX, DrawY, blank, hs, vs, frame_start, frame_count);
  modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start, frame_count);
`else
  modport master (output DrawX, DrawY, blank, hs, vs, frame_start);
  modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running 640x480@60 raster counters with delayed active-low syncs; define VGA_FRAME_CNT_EN for frame_count.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  vga_timing_if.master vga
);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic       frame_start_q, frame_start_d;
  logic       hs_raw, vs_raw;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;
`endif
  always_comb begin
    hc_d          = (hc_q == H_LAST) ? '0 : hc_q + 10'd1;
    vc_d          = (hc_q != H_LAST) ? vc_q : (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    frame_start_d = (hc_q == H_LAST) && (vc_q == V_LAST);
    hs_raw        = !(hc_q >= HS_BEG && hc_q < HS_END);
    vs_raw        = !(vc_q >= VS_BEG && vc_q < VS_END);
`ifdef VGA_FRAME_CNT_EN
    frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
`endif
  end
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      frame_start_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      frame_count_q <= '0;
`endif
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_CNT_EN
      frame_count_q <= frame_count_d;
`endif
    end
  end
  assign vga.DrawX       = hc_q;
  assign vga.DrawY       = vc_q;
  assign vga.blank       = (hc_q < H_VIS) && (vc_q < V_VIS);
  assign vga.frame_start = frame_start_q;
`ifdef VGA_FRAME_CNT_EN
  assign vga.frame_count = frame_count_q;
`endif
  // syncs lag the counters to line up with the downstream pixel pipeline
  if (SYNC_DELAY == 0) begin : g_nodly
    assign vga.hs = hs_raw;
    assign vga.vs = vs_raw;
  end else begin : g_dly
    logic [SYNC_DELAY-1:0] hs_q, hs_d, vs_q, vs_d;
    always_comb begin
      hs_d = (hs_q << 1) | SYNC_DELAY'(hs_raw);
      vs_d = (vs_q << 1) | SYNC_DELAY'(vs_raw);
    end
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_q <= '1;
        vs_q <= '1;
      end else begin
        hs_q <= hs_d;
        vs_q <= vs_d;
      end
    end
    assign vga.hs = hs_q[SYNC_DELAY-1];
    assign vga.vs = vs_q[SYNC_DELAY-1];
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random run lengths and async resets on reduced-size timings, checked against a cycle-count model.
module tb_vga_timing_gen;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0, bad = 0, t = 0;
  vga_timing_if vi2 ();
  vga_timing_if vi0 ();
  vga_timing_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_DELAY(2))
    u_dly2 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(vi2));
  vga_timing_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_DELAY(0))
    u_dly0 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(vi0));
  always #5 vga_clk = ~vga_clk;
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d want=%0d", tag, t, obs, exp);
    end
  endtask
  function automatic int hsync(input int c, input int d);
    int hc;
    if (c < d) return 1;
    hc = (c - d) % HT;
    return (hc >= HV + HF && hc < HV + HF + HS) ? 0 : 1;
  endfunction
  function automatic int vsync(input int c, input int d);
    int vc;
    if (c < d) return 1;
    vc = ((c - d) / HT) % VT;
    return (vc >= VV + VF && vc < VV + VF + VS) ? 0 : 1;
  endfunction
  task automatic check_all();
    int x, y;
    x = t % HT;
    y = (t / HT) % VT;
    chk("x", int'(vi2.DrawX), x);
    chk("y", int'(vi2.DrawY), y);
    chk("blank", int'(vi2.blank), (x < HV && y < VV) ? 1 : 0);
    chk("fs", int'(vi2.frame_start), (t > 0 && t % FT == 0) ? 1 : 0);
    chk("hs_d2", int'(vi2.hs), hsync(t, 2));
    chk("vs_d2", int'(vi2.vs), vsync(t, 2));
    chk("hs_d0", int'(vi0.hs), hsync(t, 0));
    chk("vs_d0", int'(vi0.vs), vsync(t, 0));
    chk("x_d0", int'(vi0.DrawX), x);
    chk("fs_d0", int'(vi0.frame_start), (t > 0 && t % FT == 0) ? 1 : 0);
`ifdef VGA_FRAME_CNT_EN
    chk("fc", int'(vi2.frame_count), (t / FT) % 65536);
`endif
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(negedge vga_clk);
      t++;
      check_all();
    end
  endtask
  task automatic async_reset();
    #2 reset_n = 1'b0;
    t = 0;
    #1 check_all();
    repeat (2) begin
      @(negedge vga_clk);
      check_all();
    end
    #2 reset_n = 1'b1;
    check_all();
  endtask
  initial begin
    repeat (3) @(negedge vga_clk);
    check_all();
    #2 reset_n = 1'b1;
    check_all();
    run(3 * FT + 7);
    for (int i = 0; i < 8; i++) begin
      async_reset();
      run($urandom_range(1, 2 * FT + 20));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
